// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared types and helpers for the set-associative branch target buffer.
//   btb_entry_t     : one BTB way (valid, tag, target, direction counter, age)
//   CTR_MAX/CTR_MIN : saturation limits of the 2-bit direction counter
//   CTR_INIT_DEFAULT: counter value given to a freshly allocated entry
//   ctr_update()    : saturating increment/decrement of a direction counter
// ---------------------------------------------------------------------------
package btb_pkg;

   // Tag and age fields are sized for the largest legal configuration
   // (SETS=2 leaves a 29-bit tag, WAYS=8 needs a 3-bit age). Smaller
   // configurations store zero-extended values in the same fields.
   localparam int TAG_MAX_W = 29;
   localparam int AGE_MAX_W = 3;

   localparam logic [1:0] CTR_MAX          = 2'b11;
   localparam logic [1:0] CTR_MIN          = 2'b00;
   localparam logic [1:0] CTR_INIT_DEFAULT = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           ctr;
      logic [AGE_MAX_W-1:0] age;
   } btb_entry_t;

   // Moves the counter one step towards the resolved direction, sticking
   // at the strongly-taken / strongly-not-taken ends.
   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] result;
      result = ctr;
      if (taken) begin
         if (ctr != CTR_MAX) result = ctr + 2'd1;
      end else begin
         if (ctr != CTR_MIN) result = ctr - 2'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/btb_way_select.sv
// ---------------------------------------------------------------------------
// btb_way_select
// Combinational way logic for one BTB set.
//   set_entries : the WAYS entries of the set being examined
//   tag         : tag of the PC being looked up (zero-extended)
//   hit         : some valid way holds the tag
//   touch_way   : the hitting way, or the replacement victim on a miss
//   next_age    : age vector after making touch_way most recently used
// ---------------------------------------------------------------------------
module btb_way_select
   import btb_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int AGE_W = 1
) (
   input  btb_entry_t                       set_entries [WAYS],
   input  logic [TAG_MAX_W-1:0]             tag,
   output logic                             hit,
   output logic [AGE_W-1:0]                 touch_way,
   output logic [WAYS-1:0][AGE_MAX_W-1:0]   next_age
);

   localparam logic [AGE_MAX_W-1:0] OLDEST = AGE_MAX_W'(WAYS - 1);

   logic [WAYS-1:0]      hit_vec;
   logic [AGE_W-1:0]     hit_way;
   logic [AGE_MAX_W-1:0] hit_age;
   logic [AGE_W-1:0]     victim_way;
   logic                 victim_found;
   logic [AGE_MAX_W-1:0] old_age;

   // Tag compare across all ways. Allocation never creates duplicates, so
   // at most one bit of hit_vec is set and the loop simply records it.
   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      hit_age = OLDEST;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = set_entries[w].valid && (set_entries[w].tag == tag);
         if (hit_vec[w]) begin
            hit_way = AGE_W'(w);
            hit_age = set_entries[w].age;
         end
      end
      hit = |hit_vec;
   end

   // Replacement choice: the lowest-numbered empty way if there is one,
   // otherwise the least recently used way (the one holding the oldest age).
   always_comb begin
      victim_way   = '0;
      victim_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!victim_found && !set_entries[w].valid) begin
            victim_way   = AGE_W'(w);
            victim_found = 1'b1;
         end
      end
      if (!victim_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (set_entries[w].age == OLDEST) victim_way = AGE_W'(w);
         end
      end
   end

   // MRU promotion: everything younger than the touched way ages by one and
   // the touched way becomes age 0. An allocated way is treated as having
   // been the oldest, so every other way ages.
   always_comb begin
      touch_way = hit ? hit_way : victim_way;
      old_age   = hit ? hit_age : OLDEST;
      next_age  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == touch_way)
            next_age[w] = '0;
         else if (set_entries[w].age < old_age)
            next_age[w] = set_entries[w].age + AGE_MAX_W'(1);
         else
            next_age[w] = set_entries[w].age;
      end
   end

endmodule

// File: rtl/btb_assoc.sv
// ---------------------------------------------------------------------------
// btb_assoc
// N-way set-associative branch target buffer with 2-bit direction counters
// and age-based LRU replacement. Looks up the fetch PC in IF, is trained by
// the resolved branch in ID, and produces registered redirect/flush outputs.
//   CLK, RESET, STALL       : clock, synchronous active-high reset, freeze
//   Instr_PC_IN_IF          : fetch PC to look up
//   Instr_PC_IN_ID          : PC of the instruction now in ID
//   is_Branch_IN_ID         : ID instruction is a conditional branch
//   is_Taken_IN_ID          : resolved direction of that branch
//   Alt_PC_IN_ID            : resolved branch target
//   FLUSH                   : mispredict, squash IF/ID
//   take_Branch_OUT_IF      : redirect fetch to take_Alt_PC_OUT_IF
//   take_Alt_PC_OUT_IF      : redirect / next-fetch PC
// ---------------------------------------------------------------------------
module btb_assoc
   import btb_pkg::*;
#(
   parameter int         SETS     = 512,
   parameter int         WAYS     = 2,
   parameter logic [1:0] CTR_INIT = CTR_INIT_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic [31:0] Instr_PC_IN_IF,
   input  logic [31:0] Instr_PC_IN_ID,
   input  logic        is_Branch_IN_ID,
   input  logic        is_Taken_IN_ID,
   input  logic [31:0] Alt_PC_IN_ID,
   output logic        FLUSH,
   output logic        take_Branch_OUT_IF,
   output logic [31:0] take_Alt_PC_OUT_IF
);

   localparam int IDX_W = $clog2(SETS);
   localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   btb_entry_t btb_mem [SETS][WAYS];

   logic [IDX_W-1:0]     if_idx, id_idx;
   logic [TAG_MAX_W-1:0] if_tag, id_tag;
   btb_entry_t           if_set [WAYS];
   btb_entry_t           id_set [WAYS];

   logic                           if_hit, id_hit;
   logic [AGE_W-1:0]               if_way, id_way;
   logic [WAYS-1:0][AGE_MAX_W-1:0] if_next_age, id_next_age;

   logic [31:0] if_target;
   logic [1:0]  if_ctr, id_ctr;
   logic        pred_taken_if;
   logic [31:0] next_pc;

   logic        pred_taken_q;
   logic [31:0] pred_target_q;
   logic        mispredict;
   logic [31:0] recovery_pc;
   logic        id_train;
   logic        if_promote;

   assign if_idx = Instr_PC_IN_IF[IDX_W+1:2];
   assign id_idx = Instr_PC_IN_ID[IDX_W+1:2];
   assign if_tag = TAG_MAX_W'(Instr_PC_IN_IF[31:IDX_W+2]);
   assign id_tag = TAG_MAX_W'(Instr_PC_IN_ID[31:IDX_W+2]);

   // Both ports read the table before this cycle's update, so a same-set
   // IF lookup never sees the ID training result until the next cycle.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         if_set[w] = btb_mem[if_idx][w];
         id_set[w] = btb_mem[id_idx][w];
      end
   end

   btb_way_select #(.WAYS(WAYS), .AGE_W(AGE_W)) u_if_sel (
      .set_entries (if_set),
      .tag         (if_tag),
      .hit         (if_hit),
      .touch_way   (if_way),
      .next_age    (if_next_age)
   );

   btb_way_select #(.WAYS(WAYS), .AGE_W(AGE_W)) u_id_sel (
      .set_entries (id_set),
      .tag         (id_tag),
      .hit         (id_hit),
      .touch_way   (id_way),
      .next_age    (id_next_age)
   );

   // Pull target and counter out of the selected way for each port.
   always_comb begin
      if_target = '0;
      if_ctr    = '0;
      id_ctr    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == if_way) begin
            if_target = if_set[w].target;
            if_ctr    = if_set[w].ctr;
         end
         if (AGE_W'(w) == id_way) id_ctr = id_set[w].ctr;
      end
   end

   assign pred_taken_if = if_hit && if_ctr[1];
   assign next_pc       = pred_taken_if ? if_target : (Instr_PC_IN_IF + 32'd4);

   // A branch in ID was mispredicted if the direction differs, or if both
   // said taken but the stored target was stale.
   assign mispredict  = is_Branch_IN_ID &&
                        ((is_Taken_IN_ID != pred_taken_q) ||
                         (is_Taken_IN_ID && pred_taken_q && (Alt_PC_IN_ID != pred_target_q)));
   assign recovery_pc = is_Taken_IN_ID ? Alt_PC_IN_ID : (Instr_PC_IN_ID + 32'd8);

   // ID writes the table on any hit, or on a taken miss (allocation).
   // An IF hit refreshes LRU only when its instruction survives and ID is
   // not already rewriting the same set.
   assign id_train   = is_Branch_IN_ID && (id_hit || is_Taken_IN_ID);
   assign if_promote = !mispredict && if_hit && !(id_train && (id_idx == if_idx));

   // Prediction register and registered outputs. A mispredict clears the
   // prediction so the squashed bubble behind it cannot flush again.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pred_taken_q       <= 1'b0;
         pred_target_q      <= '0;
         FLUSH              <= 1'b0;
         take_Branch_OUT_IF <= 1'b0;
         take_Alt_PC_OUT_IF <= '0;
      end else if (!STALL) begin
         if (mispredict) begin
            pred_taken_q       <= 1'b0;
            pred_target_q      <= '0;
            FLUSH              <= 1'b1;
            take_Branch_OUT_IF <= 1'b1;
            take_Alt_PC_OUT_IF <= recovery_pc;
         end else begin
            pred_taken_q       <= pred_taken_if;
            pred_target_q      <= if_target;
            FLUSH              <= 1'b0;
            take_Branch_OUT_IF <= pred_taken_if;
            take_Alt_PC_OUT_IF <= next_pc;
         end
      end
   end

   // Table update: reset empties every way and restores ages to way order;
   // otherwise apply IF LRU refresh and ID training (never the same set).
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               btb_mem[s][w].valid  <= 1'b0;
               btb_mem[s][w].tag    <= '0;
               btb_mem[s][w].target <= '0;
               btb_mem[s][w].ctr    <= CTR_MIN;
               btb_mem[s][w].age    <= AGE_MAX_W'(w);
            end
         end
      end else if (!STALL) begin
         if (if_promote) begin
            for (int w = 0; w < WAYS; w++) btb_mem[if_idx][w].age <= if_next_age[w];
         end
         if (id_train) begin
            for (int w = 0; w < WAYS; w++) begin
               btb_mem[id_idx][w].age <= id_next_age[w];
               if (AGE_W'(w) == id_way) begin
                  if (id_hit) begin
                     btb_mem[id_idx][w].ctr <= ctr_update(id_ctr, is_Taken_IN_ID);
                     if (is_Taken_IN_ID) btb_mem[id_idx][w].target <= Alt_PC_IN_ID;
                  end else begin
                     btb_mem[id_idx][w].valid  <= 1'b1;
                     btb_mem[id_idx][w].tag    <= id_tag;
                     btb_mem[id_idx][w].target <= Alt_PC_IN_ID;
                     btb_mem[id_idx][w].ctr    <= CTR_INIT;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// ---------------------------------------------------------------------------
// tb_btb_assoc
// Directed self-checking bench for btb_assoc (SETS=512, WAYS=2). Each step
// drives one cycle of IF/ID inputs and queues the outputs expected one
// clock later; the queue is drained and compared after that clock edge.
// ---------------------------------------------------------------------------
module tb_btb_assoc;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        STALL;
   logic [31:0] Instr_PC_IN_IF;
   logic [31:0] Instr_PC_IN_ID;
   logic        is_Branch_IN_ID;
   logic        is_Taken_IN_ID;
   logic [31:0] Alt_PC_IN_ID;
   logic        FLUSH;
   logic        take_Branch_OUT_IF;
   logic [31:0] take_Alt_PC_OUT_IF;

   typedef struct packed {
      logic        flush;
      logic        take;
      logic [31:0] alt;
   } sbEntry_t;

   sbEntry_t scoreboard [$];
   int       vectors     = 0;
   int       miscompares = 0;
   int       stepNum     = 0;

   btb_assoc #(.SETS(512), .WAYS(2), .CTR_INIT(2'b10)) dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .STALL              (STALL),
      .Instr_PC_IN_IF     (Instr_PC_IN_IF),
      .Instr_PC_IN_ID     (Instr_PC_IN_ID),
      .is_Branch_IN_ID    (is_Branch_IN_ID),
      .is_Taken_IN_ID     (is_Taken_IN_ID),
      .Alt_PC_IN_ID       (Alt_PC_IN_ID),
      .FLUSH              (FLUSH),
      .take_Branch_OUT_IF (take_Branch_OUT_IF),
      .take_Alt_PC_OUT_IF (take_Alt_PC_OUT_IF)
   );

   // Free-running 10-time-unit clock.
   always #5 CLK = ~CLK;

   // Pops the oldest expectation and compares all three registered outputs.
   task automatic checkOutput();
      sbEntry_t expEntry;
      if (scoreboard.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL step%0d.queue: observed empty scoreboard, required one entry", stepNum);
         return;
      end
      expEntry = scoreboard.pop_front();
      vectors++;
      assert (FLUSH === expEntry.flush) else begin
         miscompares++;
         $error("FAIL step%0d.flush: observed %b required %b", stepNum, FLUSH, expEntry.flush);
      end
      vectors++;
      assert (take_Branch_OUT_IF === expEntry.take) else begin
         miscompares++;
         $error("FAIL step%0d.take: observed %b required %b", stepNum, take_Branch_OUT_IF, expEntry.take);
      end
      vectors++;
      assert (take_Alt_PC_OUT_IF === expEntry.alt) else begin
         miscompares++;
         $error("FAIL step%0d.alt: observed %h required %h", stepNum, take_Alt_PC_OUT_IF, expEntry.alt);
      end
   endtask

   // Drives one cycle of inputs, records what the outputs must be after the
   // next rising edge, then waits for that edge and checks.
   task automatic applyStimulus(input logic [31:0] ifPc, input logic [31:0] idPc,
                                input logic br, input logic tk, input logic [31:0] altPc,
                                input logic stall, input logic rst,
                                input logic expFlush, input logic expTake, input logic [31:0] expAlt);
      Instr_PC_IN_IF  = ifPc;
      Instr_PC_IN_ID  = idPc;
      is_Branch_IN_ID = br;
      is_Taken_IN_ID  = tk;
      Alt_PC_IN_ID    = altPc;
      STALL           = stall;
      RESET           = rst;
      scoreboard.push_back({expFlush, expTake, expAlt});
      stepNum++;
      @(posedge CLK);
      #1;
      checkOutput();
   endtask

   initial begin
      RESET           = 1'b1;
      STALL           = 1'b0;
      Instr_PC_IN_IF  = '0;
      Instr_PC_IN_ID  = '0;
      is_Branch_IN_ID = 1'b0;
      is_Taken_IN_ID  = 1'b0;
      Alt_PC_IN_ID    = '0;

      // Reset: all outputs cleared
      applyStimulus(32'h0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
      applyStimulus(32'h0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0);

      // Cold lookup: sequential next PC
      applyStimulus(32'h0040_0000, 32'h0,         0, 0, 32'h0, 0, 0, 0, 0, 32'h0040_0004);
      applyStimulus(32'h100,       32'h0040_0000, 0, 0, 32'h0, 0, 0, 0, 0, 32'h104);

      // Taken miss at 0x100 -> flush to 0x200, allocate with ctr=2
      applyStimulus(32'h104, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 32'h200);
      applyStimulus(32'h200, 32'h104, 0, 0, 32'h0,   0, 0, 0, 0, 32'h204);
      applyStimulus(32'h100, 32'h200, 0, 0, 32'h0,   0, 0, 0, 1, 32'h200);

      // Not-taken twice: flush to 0x108 first, then counter reaches 0
      applyStimulus(32'h200, 32'h100, 1, 0, 32'h200, 0, 0, 1, 1, 32'h108);
      applyStimulus(32'h108, 32'h200, 0, 0, 32'h0,   0, 0, 0, 0, 32'h10C);
      applyStimulus(32'h100, 32'h108, 0, 0, 32'h0,   0, 0, 0, 0, 32'h104);
      applyStimulus(32'h104, 32'h100, 1, 0, 32'h200, 0, 0, 0, 0, 32'h108);
      applyStimulus(32'h100, 32'h104, 0, 0, 32'h0,   0, 0, 0, 0, 32'h104);

      // Stall with a pending mispredict: everything holds, then flush
      for (int i = 0; i < 3; i++)
         applyStimulus(32'h104, 32'h100, 1, 1, 32'h200, 1, 0, 0, 0, 32'h104);
      applyStimulus(32'h104, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 32'h200);
      applyStimulus(32'h200, 32'h104, 0, 0, 32'h0,   0, 0, 0, 0, 32'h204);
      applyStimulus(32'h100, 32'h200, 0, 0, 32'h0,   0, 0, 0, 0, 32'h104);

      // Train back to weakly taken so the entry visibly predicts taken
      applyStimulus(32'h104, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 32'h200);
      applyStimulus(32'h200, 32'h104, 0, 0, 32'h0,   0, 0, 0, 0, 32'h204);
      applyStimulus(32'h100, 32'h200, 0, 0, 32'h0,   0, 0, 0, 1, 32'h200);

      // Reset mid-training: outputs zero, old entry gone
      applyStimulus(32'h200, 32'h100, 1, 1, 32'h200, 0, 1, 0, 0, 32'h0);
      applyStimulus(32'h100, 32'h200, 0, 0, 32'h0,   0, 0, 0, 0, 32'h104);

      // Fill set 0x40 with 0x100 then 0x900
      applyStimulus(32'h104,  32'h100,  1, 1, 32'h200,  0, 0, 1, 1, 32'h200);
      applyStimulus(32'h200,  32'h104,  0, 0, 32'h0,    0, 0, 0, 0, 32'h204);
      applyStimulus(32'h900,  32'h200,  0, 0, 32'h0,    0, 0, 0, 0, 32'h904);
      applyStimulus(32'h904,  32'h900,  1, 1, 32'h2000, 0, 0, 1, 1, 32'h2000);
      applyStimulus(32'h2000, 32'h904,  0, 0, 32'h0,    0, 0, 0, 0, 32'h2004);

      // 0x1100 evicts the LRU way (0x100)
      applyStimulus(32'h1100, 32'h2000, 0, 0, 32'h0,    0, 0, 0, 0, 32'h1104);
      applyStimulus(32'h1104, 32'h1100, 1, 1, 32'h3000, 0, 0, 1, 1, 32'h3000);
      applyStimulus(32'h3000, 32'h1104, 0, 0, 32'h0,    0, 0, 0, 0, 32'h3004);
      applyStimulus(32'h100,  32'h3000, 0, 0, 32'h0,    0, 0, 0, 0, 32'h104);

      // IF hit on 0x900 refreshes it; correct prediction at 0x900 in ID
      // (no flush) while 0x1100 hits in IF on the same set, so ID owns LRU
      applyStimulus(32'h900,  32'h100,  0, 0, 32'h0,    0, 0, 0, 1, 32'h2000);
      applyStimulus(32'h1100, 32'h900,  1, 1, 32'h2000, 0, 0, 0, 1, 32'h3000);
      applyStimulus(32'h3000, 32'h1100, 0, 0, 32'h0,    0, 0, 0, 0, 32'h3004);

      // Reallocating 0x100 must now evict 0x1100, keeping 0x900
      applyStimulus(32'h100,  32'h3000, 0, 0, 32'h0,    0, 0, 0, 0, 32'h104);
      applyStimulus(32'h104,  32'h100,  1, 1, 32'h200,  0, 0, 1, 1, 32'h200);
      applyStimulus(32'h200,  32'h104,  0, 0, 32'h0,    0, 0, 0, 0, 32'h204);
      applyStimulus(32'h1100, 32'h200,  0, 0, 32'h0,    0, 0, 0, 0, 32'h1104);
      applyStimulus(32'h900,  32'h1100, 0, 0, 32'h0,    0, 0, 0, 1, 32'h2000);
      applyStimulus(32'h100,  32'h900,  0, 0, 32'h0,    0, 0, 0, 1, 32'h200);

      // Taken with a different target than predicted -> flush to new target
      applyStimulus(32'h0,    32'h100,  1, 1, 32'h204,  0, 0, 1, 1, 32'h204);
      applyStimulus(32'h204,  32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 32'h208);

      // PC+4 wraps modulo 2^32
      applyStimulus(32'hFFFF_FFFC, 32'h204, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised N-way set-associative branch target buffer with per-entry 2-bit saturating direction counters, age-based LRU replacement and registered redirect/flush outputs. It looks up the fetch PC in IF and is trained by the resolved branch in ID. It replaces the fixed 512x2 BTB and its separate counter array in the fetch stage.

## Interface
- SETS, 512: number of sets; power of two, 2..4096; IDX_W = log2(SETS)
- WAYS, 2: associativity; power of two, 1..8; AGE_W = max(1, log2(WAYS))
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken)
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- STALL  in  1  pipeline stall; freezes all state
- Instr_PC_IN_IF  in  32  fetch PC to look up
- Instr_PC_IN_ID  in  32  PC of instruction in ID
- is_Branch_IN_ID  in  1  ID instruction is a conditional branch
- is_Taken_IN_ID  in  1  resolved direction; valid when is_Branch_IN_ID
- Alt_PC_IN_ID  in  32  resolved branch target
- FLUSH  out  1  mispredict; squash IF/ID contents
- take_Branch_OUT_IF  out  1  redirect fetch to take_Alt_PC_OUT_IF
- take_Alt_PC_OUT_IF  out  32  redirect / next-fetch PC

## Operation
- Address split: index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2]; PC[1:0] ignored.
- Entry: valid, tag, 32-bit target, 2-bit ctr, AGE_W-bit age. Age 0 = most recently used.
- Lookup (IF): hit = valid && tag match; at most one way hits (allocation prevents duplicates). Predict taken iff hit && ctr[1]. Next PC = target if predicted taken, else PC+4.
- Prediction register: each non-stalled cycle captures {pred_taken, pred_target} of the IF lookup; it is the prediction for the instruction in ID next cycle.
- Mispredict, evaluated when is_Branch_IN_ID: (is_Taken != pred_taken) or (is_Taken && pred_taken && Alt_PC != pred_target).
- Recovery PC: Alt_PC_IN_ID if taken, else Instr_PC_IN_ID + 8 (delay slot).
- Training on is_Branch_IN_ID:
  - hit: ctr +1 if taken, -1 if not, saturating at 3/0; target <= Alt_PC if taken; way becomes MRU.
  - miss and taken: allocate lowest-index invalid way, else the way with age WAYS-1; write valid=1, tag, Alt_PC, CTR_INIT; way becomes MRU.
  - miss and not taken: no change.
- MRU promotion: ways with age < old age of the touched way increment; touched way gets 0. A newly allocated invalid way's old age counts as WAYS-1.
- A non-mispredicted IF hit also promotes that way to MRU unless ID training touches the same set this cycle (ID wins).
- Arithmetic: PC+4 and PC+8 modulo 2^32, no carry out.

## Timing
- Lookup is combinational from table state; all outputs registered, valid one cycle after Instr_PC_IN_IF.
- Outputs per cycle: mispredict -> FLUSH=1, take_Branch=1, Alt_PC=recovery PC, prediction register cleared to not-taken. Otherwise FLUSH=0, take_Branch=pred_taken, Alt_PC=next PC.
- FLUSH is high exactly one cycle per mispredict; the cleared prediction register means the following bubble cannot trigger a second flush.
- Same-set IF lookup and ID update in one cycle: lookup sees pre-update state (read-before-write).
- STALL=1: table, prediction register and outputs hold; no training.
- RESET=1 (overrides STALL, any cycle): all valid=0, ages set to way index, ctr=0, prediction register cleared, FLUSH=0, take_Branch_OUT_IF=0, take_Alt_PC_OUT_IF=0. Training is ignored during reset.

## Structure
- Package btb_pkg: btb_entry_t struct, CTR_MAX/CTR_MIN, CTR_INIT default, and a saturating-counter update function.
- Sub-module btb_way_select: per-set hit vector, hit-way encode, victim select and next-age vector for one set. Instantiate once for the IF port and once for the ID port.

## Test plan
- Reset, then look up 0x0040_0000 -> take_Branch=0 and Alt_PC=0x0040_0004 next cycle, FLUSH=0.
- Taken branch at 0x100 to 0x200 (miss) -> FLUSH=1, Alt_PC=0x200. Refetch 0x100 -> taken (ctr=2), Alt_PC=0x200.
- Branch at 0x100 resolves not-taken twice -> ctr 2->1->0. First not-taken: FLUSH=1, Alt_PC=0x108. Later lookups are not-taken.
- WAYS=2: allocate taken branches at 0x100, 0x900, 0x1100 (same set), then look up 0x100 -> miss (0x100 evicted as LRU); 0x900 and 0x1100 still hit.
- Assert STALL for 3 cycles with a pending mispredict -> outputs and table unchanged. Release STALL -> FLUSH next cycle.
- Assert RESET mid-training -> all outputs 0 next cycle; prior entries miss.
